pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB instances).
- Generalises the fixed EX/MEM latch with configurable control and data widths.
- Adds a valid/ready handshake, stall back-pressure, synchronous flush (bubble insertion) and an optional 2-entry skid buffer so ready is registered.
- Includes a saturating bubble counter for performance debug.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_entry.sv | 38 +++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the 5-stage core:
// occupancy state encoding, default payload widths and control-bundle bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipeState_t;

    localparam int PIPE_CTRL_W = 4;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_RD_W   = 5;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMREAD  = 3;

endpackage

// File: rtl/pipe_entry.sv
// One payload slot {Ctrl, Data, Rd}. ClearCtrl zeroes only Ctrl and Rd,
// so the data words keep their last value while the slot is empty.
module pipe_entry #(
    parameter int CTRL_W    = 4,
    parameter int PAYLOAD_W = 64,
    parameter int RD_W      = 5
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Load,
    input  logic                 ClearCtrl,
    input  logic [CTRL_W-1:0]    NewCtrl,
    input  logic [PAYLOAD_W-1:0] NewData,
    input  logic [RD_W-1:0]      NewRd,
    output logic [CTRL_W-1:0]    Ctrl,
    output logic [PAYLOAD_W-1:0] Data,
    output logic [RD_W-1:0]      Rd
);

    // NOTE: the data payload is reset too, because OutData must read 0 after reset;
    // plain pipeline data would normally be left unreset.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Ctrl <= '0;
            Data <= '0;
            Rd   <= '0;
        end else if (Load) begin
            Ctrl <= NewCtrl;
            Data <= NewData;
            Rd   <= NewRd;
        end else if (ClearCtrl) begin
            Ctrl <= '0;
            Rd   <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional
// 2-entry skid buffer (registered InReady) and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int NDATA  = 2,
    parameter int RD_W   = PIPE_RD_W,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [CTRL_W-1:0]       InCtrl,
    input  logic [NDATA*DATA_W-1:0] InData,
    input  logic [RD_W-1:0]         InRd,
    input  logic                    Flush,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [CTRL_W-1:0]       OutCtrl,
    output logic [NDATA*DATA_W-1:0] OutData,
    output logic [RD_W-1:0]         OutRd,
    output logic [CNT_W-1:0]        BubbleCount
);

    localparam int PAYLOAD_W = NDATA * DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipeState_t state, stateNext;
    logic inFire, outFire;
    logic mainLoad, mainClr, skidLoad, skidClr;
    logic [CTRL_W-1:0]    skidCtrl, mainNewCtrl;
    logic [PAYLOAD_W-1:0] skidData, mainNewData;
    logic [RD_W-1:0]      skidRd, mainNewRd;

    assign OutValid = (state != ST_EMPTY);
    assign inFire   = InValid & InReady;
    assign outFire  = OutValid & OutReady;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        stateNext = state;
        mainLoad  = 1'b0;
        mainClr   = 1'b0;
        skidLoad  = 1'b0;
        skidClr   = 1'b0;
        if (Flush) begin
            stateNext = ST_EMPTY;
            mainClr   = 1'b1;
            skidClr   = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: if (inFire) begin
                    stateNext = ST_ONE;
                    mainLoad  = 1'b1;
                end
                ST_ONE: begin
                    if (inFire && outFire) begin
                        mainLoad = 1'b1;
                    end else if (inFire) begin
                        stateNext = ST_TWO;
                        skidLoad  = 1'b1;
                    end else if (outFire) begin
                        stateNext = ST_EMPTY;
                        mainClr   = 1'b1;
                    end
                end
                ST_TWO: if (outFire) begin
                    stateNext = ST_ONE;
                    mainLoad  = 1'b1;
                end
                default: stateNext = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_EMPTY;
        else       state <= stateNext;
    end

    // In TWO the only way the main entry reloads is by promoting the older skid beat.
    assign mainNewCtrl = (state == ST_TWO) ? skidCtrl : InCtrl;
    assign mainNewData = (state == ST_TWO) ? skidData : InData;
    assign mainNewRd   = (state == ST_TWO) ? skidRd   : InRd;

    pipe_entry #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W), .RD_W(RD_W)) mainEntry (
        .Clk(Clk), .Reset(Reset), .Load(mainLoad), .ClearCtrl(mainClr),
        .NewCtrl(mainNewCtrl), .NewData(mainNewData), .NewRd(mainNewRd),
        .Ctrl(OutCtrl), .Data(OutData), .Rd(OutRd)
    );

    generate
        if (SKID) begin : gSkid
            logic inReadyQ;

            pipe_entry #(.CTRL_W(CTRL_W), .PAYLOAD_W(PAYLOAD_W), .RD_W(RD_W)) skidEntry (
                .Clk(Clk), .Reset(Reset), .Load(skidLoad), .ClearCtrl(skidClr),
                .NewCtrl(InCtrl), .NewData(InData), .NewRd(InRd),
                .Ctrl(skidCtrl), .Data(skidData), .Rd(skidRd)
            );

            always_ff @(posedge Clk) begin
                if (Reset) inReadyQ <= 1'b1;
                else       inReadyQ <= (stateNext != ST_TWO);
            end
            assign InReady = inReadyQ;
        end else begin : gNoSkid
            // Without a skid slot TWO is unreachable: InReady drops whenever a held beat stalls.
            assign skidCtrl = '0;
            assign skidData = '0;
            assign skidRd   = '0;
            assign InReady  = ~OutValid | OutReady;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset)                                  BubbleCount <= '0;
        else if (!OutValid && BubbleCount != CNT_MAX) BubbleCount <= BubbleCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a SKID=1 and a SKID=0 instance with the same
// stimulus and compares both against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

    localparam int CW = 4;
    localparam int DW = 32;
    localparam int ND = 2;
    localparam int RW = 5;
    localparam int BW = 4;
    localparam int BUB_MAX = (1 << BW) - 1;

    typedef struct {
        logic          rst, iv;
        logic [CW-1:0] ctl;
        logic [63:0]   data;
        logic [RW-1:0] rd;
        logic          fl, ordy;
    } stim_t;

    typedef struct {
        stim_t         s;
        bit            chk;
        logic          ov, ir;
        logic [CW-1:0] ctl;
        logic [63:0]   data;
        logic [RW-1:0] rd;
    } vec_t;

    typedef struct {
        logic [CW-1:0] ctl;
        logic [63:0]   data;
        logic [RW-1:0] rd;
    } beat_t;

    logic Clk = 1'b0;
    logic Reset, InValid, Flush, OutReady;
    logic [CW-1:0]    InCtrl;
    logic [ND*DW-1:0] InData;
    logic [RW-1:0]    InRd;
    logic             inReady  [2];
    logic             outValid [2];
    logic [CW-1:0]    outCtrl  [2];
    logic [ND*DW-1:0] outData  [2];
    logic [RW-1:0]    outRd    [2];
    logic [BW-1:0]    bubble   [2];

    int nCompared = 0;
    int nMismatch = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NDATA(ND), .RD_W(RW), .SKID(1'b1), .CNT_W(BW)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(inReady[0]),
        .InCtrl(InCtrl), .InData(InData), .InRd(InRd), .Flush(Flush),
        .OutValid(outValid[0]), .OutReady(OutReady), .OutCtrl(outCtrl[0]),
        .OutData(outData[0]), .OutRd(outRd[0]), .BubbleCount(bubble[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NDATA(ND), .RD_W(RW), .SKID(1'b0), .CNT_W(BW)) dut0 (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(inReady[1]),
        .InCtrl(InCtrl), .InData(InData), .InRd(InRd), .Flush(Flush),
        .OutValid(outValid[1]), .OutReady(OutReady), .OutCtrl(outCtrl[1]),
        .OutData(outData[1]), .OutRd(outRd[1]), .BubbleCount(bubble[1])
    );

    // Reference model: index 0 is a 2-deep FIFO with registered ready, index 1 a 1-deep one.
    beat_t       mFifo  [2][2];
    int          mCount [2];
    logic [63:0] mLast  [2];
    int          mBub   [2];
    bit          mInit = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit expReady(input int k, input logic ordy);
        if (k == 0) return mCount[k] < 2;
        return (mCount[k] == 0) || ordy;
    endfunction

    task automatic drive(input stim_t s);
        Reset    = s.rst;
        InValid  = s.iv;
        InCtrl   = s.ctl;
        InData   = s.data;
        InRd     = s.rd;
        Flush    = s.fl;
        OutReady = s.ordy;
    endtask

    task automatic modelCheck(input stim_t s, input string tag);
        for (int k = 0; k < 2; k++) begin
            logic ov;
            ov = mCount[k] > 0;
            check($sformatf("%s[%0d].OutValid", tag, k), outValid[k], ov);
            check($sformatf("%s[%0d].InReady", tag, k), inReady[k], expReady(k, s.ordy));
            check($sformatf("%s[%0d].OutData", tag, k), outData[k], mLast[k]);
            check($sformatf("%s[%0d].OutCtrl", tag, k), outCtrl[k], ov ? mFifo[k][0].ctl : '0);
            check($sformatf("%s[%0d].OutRd", tag, k), outRd[k], ov ? mFifo[k][0].rd : '0);
            check($sformatf("%s[%0d].Bubble", tag, k), bubble[k], mBub[k]);
        end
    endtask

    task automatic modelEdge(input stim_t s);
        for (int k = 0; k < 2; k++) begin
            bit inFire, outFire;
            if (s.rst) begin
                mCount[k] = 0;
                mLast[k]  = '0;
                mBub[k]   = 0;
            end else begin
                inFire  = s.iv && expReady(k, s.ordy);
                outFire = (mCount[k] > 0) && s.ordy;
                if (mCount[k] == 0 && mBub[k] < BUB_MAX) mBub[k]++;
                if (s.fl) begin
                    mCount[k] = 0;
                end else begin
                    if (outFire) begin
                        mFifo[k][0] = mFifo[k][1];
                        mCount[k]--;
                    end
                    if (inFire && mCount[k] < 2) begin
                        mFifo[k][mCount[k]] = '{ctl: s.ctl, data: s.data, rd: s.rd};
                        mCount[k]++;
                    end
                end
                if (mCount[k] > 0) mLast[k] = mFifo[k][0].data;
            end
        end
        if (s.rst) mInit = 1;
    endtask

    task automatic applyCheck(input stim_t s, input string tag);
        @(negedge Clk);
        drive(s);
        #1;
        if (mInit) modelCheck(s, tag);
    endtask

    task automatic advance(input stim_t s);
        @(posedge Clk);
        modelEdge(s);
    endtask

    task automatic step(input stim_t s, input string tag);
        applyCheck(s, tag);
        advance(s);
    endtask

    function automatic stim_t S(input logic rst, iv, input logic [CW-1:0] ctl,
                                input logic [63:0] d, input logic [RW-1:0] rd,
                                input logic fl, ordy);
        stim_t s;
        s = '{rst: rst, iv: iv, ctl: ctl, data: d, rd: rd, fl: fl, ordy: ordy};
        return s;
    endfunction

    function automatic vec_t V(input stim_t s, input bit chk, input logic ov, ir,
                               input logic [CW-1:0] ctl, input logic [63:0] d,
                               input logic [RW-1:0] rd);
        vec_t v;
        v = '{s: s, chk: chk, ov: ov, ir: ir, ctl: ctl, data: d, rd: rd};
        return v;
    endfunction

    vec_t tbl [23];

    initial begin
        stim_t s;

        // Expected columns describe the SKID=1 instance in the cycle the inputs are applied.
        tbl[0]  = V(S(1, 0, 0, 64'h0, 0, 0, 0), 0, 0, 0, 0, 64'h0, 0);
        tbl[1]  = V(S(1, 0, 0, 64'h0, 0, 0, 0), 1, 0, 1, 0, 64'h0, 0);
        tbl[2]  = V(S(0, 1, 1, 64'h1, 1, 0, 1), 1, 0, 1, 0, 64'h0, 0);
        tbl[3]  = V(S(0, 1, 2, 64'h2, 2, 0, 1), 1, 1, 1, 1, 64'h1, 1);
        tbl[4]  = V(S(0, 1, 3, 64'h3, 3, 0, 1), 1, 1, 1, 2, 64'h2, 2);
        tbl[5]  = V(S(0, 1, 4, 64'h4, 4, 0, 1), 1, 1, 1, 3, 64'h3, 3);
        tbl[6]  = V(S(0, 1, 5, 64'h5, 5, 0, 1), 1, 1, 1, 4, 64'h4, 4);
        tbl[7]  = V(S(0, 0, 0, 64'h0, 0, 0, 1), 1, 1, 1, 5, 64'h5, 5);
        tbl[8]  = V(S(0, 0, 0, 64'h0, 0, 0, 0), 1, 0, 1, 0, 64'h5, 0);
        tbl[9]  = V(S(0, 1, 3, 64'hAAAA0000, 10, 0, 0), 1, 0, 1, 0, 64'h5, 0);
        tbl[10] = V(S(0, 1, 4, 64'hBBBB0000, 11, 0, 0), 1, 1, 1, 3, 64'hAAAA0000, 10);
        tbl[11] = V(S(0, 1, 5, 64'hCCCC0000, 12, 0, 0), 1, 1, 0, 3, 64'hAAAA0000, 10);
        tbl[12] = V(S(0, 1, 5, 64'hCCCC0000, 12, 0, 1), 1, 1, 0, 3, 64'hAAAA0000, 10);
        tbl[13] = V(S(0, 1, 5, 64'hCCCC0000, 12, 0, 0), 1, 1, 1, 4, 64'hBBBB0000, 11);
        tbl[14] = V(S(0, 1, 6, 64'hDDDD0000, 13, 1, 0), 1, 1, 0, 4, 64'hBBBB0000, 11);
        tbl[15] = V(S(0, 0, 0, 64'h0, 0, 0, 1), 1, 0, 1, 0, 64'hBBBB0000, 0);
        tbl[16] = V(S(0, 0, 0, 64'h0, 0, 0, 1), 1, 0, 1, 0, 64'hBBBB0000, 0);
        tbl[17] = V(S(0, 1, 7, 64'hEEEE0000, 14, 0, 1), 1, 0, 1, 0, 64'hBBBB0000, 0);
        tbl[18] = V(S(0, 1, 8, 64'hFFFF0000, 15, 1, 1), 1, 1, 1, 7, 64'hEEEE0000, 14);
        tbl[19] = V(S(0, 0, 0, 64'h0, 0, 0, 1), 1, 0, 1, 0, 64'hEEEE0000, 0);
        tbl[20] = V(S(0, 1, 9, 64'h11, 16, 0, 0), 1, 0, 1, 0, 64'hEEEE0000, 0);
        tbl[21] = V(S(1, 1, 9, 64'h22, 17, 0, 0), 1, 1, 1, 9, 64'h11, 16);
        tbl[22] = V(S(0, 0, 0, 64'h0, 0, 0, 0), 1, 0, 1, 0, 64'h0, 0);

        for (int i = 0; i < 23; i++) begin
            applyCheck(tbl[i].s, $sformatf("vec%0d", i));
            if (tbl[i].chk) begin
                check($sformatf("vec%0d.OutValid", i), outValid[0], tbl[i].ov);
                check($sformatf("vec%0d.InReady", i), inReady[0], tbl[i].ir);
                check($sformatf("vec%0d.OutCtrl", i), outCtrl[0], tbl[i].ctl);
                check($sformatf("vec%0d.OutData", i), outData[0], tbl[i].data);
                check($sformatf("vec%0d.OutRd", i), outRd[0], tbl[i].rd);
            end
            advance(tbl[i].s);
        end

        // Bubble counter saturation and clear.
        step(S(1, 0, 0, 64'h0, 0, 0, 0), "bub_rst");
        step(S(1, 0, 0, 64'h0, 0, 0, 0), "bub_rst");
        for (int i = 0; i < 20; i++) step(S(0, 0, 0, 64'h0, 0, 0, 1), "bub_idle");
        #1;
        check("bub_sat[0]", bubble[0], 15);
        check("bub_sat[1]", bubble[1], 15);
        step(S(1, 0, 0, 64'h0, 0, 0, 0), "bub_clr");
        #1;
        check("bub_clr[0]", bubble[0], 0);
        check("bub_clr[1]", bubble[1], 0);

        // Single-entry mode: combinational ready follows OutReady within one cycle.
        step(S(0, 1, 1, 64'h5151, 1, 0, 1), "s0_load");
        @(negedge Clk);
        s = S(0, 1, 2, 64'h5252, 2, 0, 0);
        drive(s);
        #1;
        check("s0_ready_stall", inReady[1], 0);
        s.ordy = 1'b1;
        drive(s);
        #1;
        check("s0_ready_release", inReady[1], 1);
        modelCheck(s, "s0_comb");
        advance(s);
        step(S(0, 1, 3, 64'h5353, 3, 0, 1), "s0_b2b");
        step(S(0, 1, 4, 64'h5454, 4, 0, 1), "s0_b2b");
        #1;
        check("s0_b2b.OutValid", outValid[1], 1);
        check("s0_b2b.OutData", outData[1], 64'h5454);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            s.rst  = ($urandom_range(0, 99) == 0);
            s.iv   = ($urandom_range(0, 3) != 0);
            s.ctl  = CW'($urandom_range(0, 15));
            s.data = {32'($urandom), 32'($urandom)};
            s.rd   = RW'($urandom_range(0, 31));
            s.fl   = ($urandom_range(0, 15) == 0);
            s.ordy = ($urandom_range(0, 2) != 0);
            step(s, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
